ram_dbg_scheduler: RTL and testbench

- Shares the debug access port of a bank of i4002 RAM chips between NUM_REQ host-side requesters (e.g. AXI loader, snapshot engine), using round-robin arbitration.
- Regenerates the chips' instruction-cycle phase from sync. Debug strobes never land in X1 or X2, so a debug access never suppresses a CPU read-latch or CPU write.
- One transaction in flight; fixed-latency response routed back to the owning requester.

---
 rtl/ram_dbg_scheduler_if.sv | 30 +++
 rtl/ram_dbg_scheduler.sv | 169 ++++++++++++++++
 tb/tb_ram_dbg_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dbg_scheduler_if.sv
// rtl/ram_dbg_scheduler_if.sv - requester and i4002 debug-bus bundle for ram_dbg_scheduler
interface ram_dbg_scheduler_if #(
  parameter int NUM_REQ   = 2,
  parameter int NUM_CHIPS = 4
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     req_write;
  logic [NUM_REQ*12-1:0]  req_addr;
  logic [NUM_REQ*8-1:0]   req_wdata;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [7:0]             rsp_data;
  logic                   rsp_err;
  logic [11:0]            dbg_addr;
  logic [7:0]             dbg_wdata;
  logic                   dbg_wen;
  logic                   dbg_ren;
  logic [NUM_CHIPS*8-1:0] dbg_rdata;
  logic [NUM_CHIPS-1:0]   dbg_rdata_vld;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, dbg_rdata, dbg_rdata_vld,
    input  req_ready, rsp_valid, rsp_data, rsp_err, dbg_addr, dbg_wdata, dbg_wen, dbg_ren
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, dbg_rdata, dbg_rdata_vld,
    output req_ready, rsp_valid, rsp_data, rsp_err, dbg_addr, dbg_wdata, dbg_wen, dbg_ren
  );
endinterface

// File: rtl/ram_dbg_scheduler.sv
// rtl/ram_dbg_scheduler.sv - round-robin sharing of the i4002 debug port, strobes kept out of X1/X2
// Optional RAM_DBG_RANGE_CHECK_EN: requests for chips >= NUM_CHIPS answer with an error and no strobe.
module ram_dbg_scheduler #(
  parameter int NUM_REQ   = 2,
  parameter int NUM_CHIPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sync,
  ram_dbg_scheduler_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_CAPTURE, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         phase_q, phase_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic               write_q, write_d;
  logic [11:0]        dbg_addr_q, dbg_addr_d;
  logic [7:0]         dbg_wdata_q, dbg_wdata_d;
  logic               dbg_wen_q, dbg_wen_d;
  logic               dbg_ren_q, dbg_ren_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic               blocked;
  logic               win_found;
  logic [IW-1:0]      win;
  logic [IW:0]        cand;
  logic [NUM_REQ-1:0] grant;
  logic [11:0]        sel_addr;
  logic [7:0]         sel_wdata;
  logic               sel_write;
  logic               out_of_range;
  logic [7:0]         cap_data;
  logic               cap_err;

  // Scan candidates farthest-first so the nearest valid index after ptr_q is the one left standing.
  always_comb begin
    win       = ptr_q;
    win_found = 1'b0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (bus.req_valid[cand[IW-1:0]]) begin
        win       = cand[IW-1:0];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr  = bus.req_addr[win*12 +: 12];
    sel_wdata = bus.req_wdata[win*8 +: 8];
    sel_write = bus.req_write[win];
  end

`ifdef RAM_DBG_RANGE_CHECK_EN
  assign out_of_range = ({1'b0, sel_addr[8], sel_addr[7:5]} >= 5'(NUM_CHIPS));
`else
  assign out_of_range = 1'b0;
`endif

  // Lowest responding chip supplies the data; zero or several responders flag an error.
  always_comb begin
    cap_data = 8'h00;
    for (int i = NUM_CHIPS - 1; i >= 0; i--) begin
      if (bus.dbg_rdata_vld[i]) cap_data = bus.dbg_rdata[i*8 +: 8];
    end
    cap_err = (bus.dbg_rdata_vld == '0) ||
              ((bus.dbg_rdata_vld & (bus.dbg_rdata_vld - NUM_CHIPS'(1))) != '0);
  end

  always_comb begin
    phase_d     = sync ? 4'd0 : phase_q + 4'd1;
    blocked     = (phase_d == 4'd5) || (phase_d == 4'd6);
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    write_d     = write_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_wdata_d = dbg_wdata_q;
    dbg_wen_d   = 1'b0;
    dbg_ren_d   = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = 8'h00;
    rsp_err_d   = 1'b0;
    grant       = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found && !blocked && !rst) begin
          grant[win] = 1'b1;
          ptr_d      = win;
          owner_d    = win;
          write_d    = sel_write;
          if (out_of_range) begin
            state_d          = S_RESP;
            rsp_valid_d[win] = 1'b1;
            rsp_err_d        = 1'b1;
          end else begin
            state_d     = S_STROBE;
            dbg_addr_d  = sel_addr;
            dbg_wdata_d = sel_wdata;
            dbg_wen_d   = sel_write;
            dbg_ren_d   = !sel_write;
          end
        end
      end
      S_STROBE: begin
        if (write_q) begin
          state_d              = S_RESP;
          rsp_valid_d[owner_q] = 1'b1;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d              = S_RESP;
        rsp_valid_d[owner_q] = 1'b1;
        rsp_data_d           = cap_data;
        rsp_err_d            = cap_err;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= 4'd0;
      ptr_q       <= IW'(NUM_REQ - 1);
      owner_q     <= '0;
      write_q     <= 1'b0;
      dbg_addr_q  <= 12'h000;
      dbg_wdata_q <= 8'h00;
      dbg_wen_q   <= 1'b0;
      dbg_ren_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_wdata_q <= dbg_wdata_d;
      dbg_wen_q   <= dbg_wen_d;
      dbg_ren_q   <= dbg_ren_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.dbg_addr  = dbg_addr_q;
  assign bus.dbg_wdata = dbg_wdata_q;
  assign bus.dbg_wen   = dbg_wen_q;
  assign bus.dbg_ren   = dbg_ren_q;
endmodule

// File: tb/tb_ram_dbg_scheduler.sv
// tb/tb_ram_dbg_scheduler.sv - self-checking bench for ram_dbg_scheduler with i4002 chip and phase models
`timescale 1ns/1ps
module tb_ram_dbg_scheduler;
  localparam int NR = 2;
  localparam int NC = 4;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sync = 1'b0;

  ram_dbg_scheduler_if #(.NUM_REQ(NR), .NUM_CHIPS(NC)) bus ();
  ram_dbg_scheduler #(.NUM_REQ(NR), .NUM_CHIPS(NC)) dut (.clk(clk), .rst(rst), .sync(sync), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int tb_phase = 0;
  int scnt = 0;
  bit sync_en = 1'b1;
  int last_g = NR - 1;
  logic [7:0] mem [4096];

  always @(posedge clk) tb_phase = rst ? 0 : (sync ? 0 : (tb_phase + 1) % 16);

  // Strobes and grants must never touch X1/X2.
  always @(negedge clk) begin : phase_mon
    int nxt;
    #2;
    nxt = sync ? 0 : (tb_phase + 1) % 16;
    if (!rst && bus.req_ready != '0) begin
      n_cmp++;
      if (nxt == 5 || nxt == 6) begin
        n_err++;
        $display("FAIL grant_blocked: req_ready=%b with next_phase=%0d, required no grant", bus.req_ready, nxt);
      end
    end
    if (!rst && (bus.dbg_wen || bus.dbg_ren)) begin
      n_cmp++;
      if (tb_phase == 5 || tb_phase == 6) begin
        n_err++;
        $display("FAIL strobe_phase: strobe in phase %0d, required not 5/6", tb_phase);
      end
    end
  end

  function automatic int chip_of(input logic [11:0] a);
    return int'({a[8], a[7:5]});
  endfunction

  function automatic logic [NR-1:0] onehot(input int r);
    onehot    = '0;
    onehot[r] = 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk);
    sync = sync_en && (scnt == 7);
    scnt = (scnt + 1) % 8;
  endtask

  task automatic wait_grant(output int waited);
    waited = 0;
    #1;
    while (bus.req_ready == '0 && waited < 40) begin
      tick();
      #1;
      waited++;
    end
  endtask

  task automatic do_txn(input int r, input bit wr, input logic [11:0] a, input logic [7:0] wd,
                        input int vmode, input int exp_wait, input string nm);
    int waited, c, c2;
    logic [7:0] ed;
    logic ee;
    c  = chip_of(a);
    ed = 8'h00;
    ee = 1'b1;
    tick();
    bus.req_valid[r]         = 1'b1;
    bus.req_write[r]         = wr;
    bus.req_addr[r*12 +: 12] = a;
    bus.req_wdata[r*8 +: 8]  = wd;
    wait_grant(waited);
    n_cmp++;
    if (bus.req_ready !== onehot(r)) begin
      n_err++;
      $display("FAIL %s_grant: req_ready=%b required %b", nm, bus.req_ready, onehot(r));
    end
    if (exp_wait >= 0) begin
      n_cmp++;
      if (waited != exp_wait) begin
        n_err++;
        $display("FAIL %s_wait: waited %0d cycles, required %0d", nm, waited, exp_wait);
      end
    end
    last_g = r;
    tick();
    bus.req_valid[r] = 1'b0;
    #1;
    n_cmp++;
    if (bus.dbg_wen !== wr || bus.dbg_ren !== !wr || bus.dbg_addr !== a ||
        (wr && bus.dbg_wdata !== wd) || bus.rsp_valid !== '0) begin
      n_err++;
      $display("FAIL %s_strobe: wen=%b ren=%b addr=%h wdata=%h rsp_valid=%b required wen=%b ren=%b addr=%h wdata=%h",
               nm, bus.dbg_wen, bus.dbg_ren, bus.dbg_addr, bus.dbg_wdata, bus.rsp_valid, wr, !wr, a, wd);
    end
    if (!wr) begin
      bus.dbg_rdata_vld = '0;
      for (int i = 0; i < NC; i++) bus.dbg_rdata[i*8 +: 8] = ~mem[a] ^ 8'(i);
      if (vmode == 0 && c < NC) begin
        bus.dbg_rdata_vld[c]     = 1'b1;
        bus.dbg_rdata[c*8 +: 8]  = mem[a];
        ed = mem[a];
        ee = 1'b0;
      end else if (vmode == 2) begin
        c2 = (c == NC - 1) ? 0 : NC - 1;
        bus.dbg_rdata_vld[c]     = 1'b1;
        bus.dbg_rdata_vld[c2]    = 1'b1;
        bus.dbg_rdata[c*8 +: 8]  = mem[a];
        bus.dbg_rdata[c2*8 +: 8] = mem[a] ^ 8'h5A;
        ed = (c < c2) ? mem[a] : (mem[a] ^ 8'h5A);
      end
    end
    tick();
    #1;
    if (wr) begin
      ed = 8'h00;
      ee = 1'b0;
      if (c < NC) mem[a] = wd;
    end else begin
      n_cmp++;
      if (bus.rsp_valid !== '0 || bus.dbg_ren !== 1'b0) begin
        n_err++;
        $display("FAIL %s_capture: rsp_valid=%b ren=%b required 0 0", nm, bus.rsp_valid, bus.dbg_ren);
      end
      tick();
      #1;
    end
    n_cmp++;
    if (bus.rsp_valid !== onehot(r) || bus.rsp_data !== ed || bus.rsp_err !== ee) begin
      n_err++;
      $display("FAIL %s_rsp: valid=%b data=%h err=%b required valid=%b data=%h err=%b",
               nm, bus.rsp_valid, bus.rsp_data, bus.rsp_err, onehot(r), ed, ee);
    end
    bus.dbg_rdata_vld = '0;
  endtask

  // Writes only; the reference decides grants from idle time, phase and round-robin order.
  task automatic run_writes(input int ncyc, input int pct, input string nm);
    int busy_until, stb_t, rsp_t, rsp_w, nxt, w, clr_idx;
    bit found, clr;
    logic [11:0] stb_a;
    logic [7:0] stb_d;
    logic [NR-1:0] exp_ready, exp_rsp;
    busy_until = 0; stb_t = -1; rsp_t = -1; rsp_w = 0; clr = 0; clr_idx = 0;
    stb_a = '0; stb_d = '0;
    for (int t = 0; t < ncyc + 16; t++) begin
      tick();
      if (clr) begin
        bus.req_valid[clr_idx] = 1'b0;
        clr = 0;
      end
      for (int r = 0; r < NR; r++) begin
        if (!bus.req_valid[r] && t < ncyc && $urandom_range(99) < pct) begin
          bus.req_valid[r]         = 1'b1;
          bus.req_write[r]         = 1'b1;
          bus.req_addr[r*12 +: 12] = 12'($urandom);
          bus.req_wdata[r*8 +: 8]  = 8'($urandom);
        end
      end
      #1;
      nxt = sync ? 0 : (tb_phase + 1) % 16;
      exp_ready = '0;
      w = last_g;
      found = 0;
      if (t >= busy_until && nxt != 5 && nxt != 6) begin
        for (int k = 1; k <= NR; k++) begin
          if (!found && bus.req_valid[(last_g + k) % NR]) begin
            w = (last_g + k) % NR;
            found = 1;
          end
        end
        if (found) exp_ready[w] = 1'b1;
      end
      n_cmp++;
      if (bus.req_ready !== exp_ready) begin
        n_err++;
        $display("FAIL %s_ready t=%0d: req_ready=%b required %b", nm, t, bus.req_ready, exp_ready);
      end
      exp_rsp = (t == rsp_t) ? onehot(rsp_w) : '0;
      n_cmp++;
      if (bus.rsp_valid !== exp_rsp || bus.rsp_data !== 8'h00 || bus.rsp_err !== 1'b0) begin
        n_err++;
        $display("FAIL %s_rsp t=%0d: valid=%b data=%h err=%b required valid=%b data=00 err=0",
                 nm, t, bus.rsp_valid, bus.rsp_data, bus.rsp_err, exp_rsp);
      end
      n_cmp++;
      if (bus.dbg_wen !== (t == stb_t) || bus.dbg_ren !== 1'b0 ||
          (t == stb_t && (bus.dbg_addr !== stb_a || bus.dbg_wdata !== stb_d))) begin
        n_err++;
        $display("FAIL %s_strobe t=%0d: wen=%b ren=%b addr=%h wdata=%h required wen=%b addr=%h wdata=%h",
                 nm, t, bus.dbg_wen, bus.dbg_ren, bus.dbg_addr, bus.dbg_wdata, t == stb_t, stb_a, stb_d);
      end
      if (found) begin
        last_g = w; busy_until = t + 3; stb_t = t + 1; rsp_t = t + 2; rsp_w = w;
        stb_a = bus.req_addr[w*12 +: 12];
        stb_d = bus.req_wdata[w*8 +: 8];
        clr = 1; clr_idx = w;
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_write = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_cmp++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.dbg_addr,
           bus.dbg_wdata, bus.dbg_wen, bus.dbg_ren} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: ready=%b rsp_valid=%b data=%h err=%b addr=%h wdata=%h wen=%b ren=%b required all 0",
                 bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.dbg_addr,
                 bus.dbg_wdata, bus.dbg_wen, bus.dbg_ren);
      end
    end
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
    last_g = NR - 1;
  endtask

  task automatic test_read_basic();
    mem[12'h012] = 8'hA5;
    do_txn(0, 1'b0, 12'h012, 8'h00, 0, -1, "read_basic");
  endtask

  task automatic test_back_to_back();
    run_writes(14, 100, "back_to_back");
  endtask

  task automatic test_blocked();
    sync_en = 1'b0;
    tick();
    sync = 1'b1;
    repeat (4) tick();
    do_txn(0, 1'b1, 12'h0A7, 8'h3C, 0, 2, "blocked");
    sync_en = 1'b1;
  endtask

  task automatic test_vld_cases();
    do_txn(1, 1'b0, 12'h025, 8'h00, 1, -1, "no_vld");
    do_txn(0, 1'b0, 12'h04B, 8'h00, 2, -1, "multi_vld");
    do_txn(1, 1'b0, 12'h061, 8'h00, 2, -1, "multi_vld_hi");
  endtask

  task automatic test_random_rw();
    logic [11:0] a;
    int r;
    for (int i = 0; i < 8; i++) begin
      a = 12'($urandom) & 12'hE7F;
      r = $urandom_range(NR - 1);
      if ($urandom_range(1) == 1) do_txn(r, 1'b1, a, 8'($urandom), 0, -1, "rand_write");
      do_txn((r + 1) % NR, 1'b0, a, 8'h00, $urandom_range(2), -1, "rand_read");
    end
    run_writes(60, 30, "rand_writes");
  endtask

  task automatic test_rst_mid();
    int waited;
    tick();
    bus.req_valid[0] = 1'b1;
    bus.req_write[0] = 1'b0;
    bus.req_addr[0 +: 12] = 12'h034;
    wait_grant(waited);
    n_cmp++;
    if (bus.req_ready !== onehot(0)) begin
      n_err++;
      $display("FAIL rst_mid_grant: req_ready=%b required %b", bus.req_ready, onehot(0));
    end
    tick();
    bus.req_valid[0] = 1'b0;
    tick();
    bus.dbg_rdata_vld[1] = 1'b1;
    bus.dbg_rdata[8 +: 8] = 8'h77;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.dbg_rdata_vld = '0;
    bus.req_valid = '1;
    bus.req_write = '1;
    bus.req_addr  = {12'h0C1, 12'h012};
    bus.req_wdata = {8'h22, 8'h11};
    #1;
    n_cmp++;
    if (bus.rsp_valid !== '0) begin
      n_err++;
      $display("FAIL rst_mid_norsp: rsp_valid=%b required 0", bus.rsp_valid);
    end
    #0;
    wait_grant(waited);
    n_cmp++;
    if (bus.req_ready !== onehot(0)) begin
      n_err++;
      $display("FAIL rst_mid_ptr: req_ready=%b required %b", bus.req_ready, onehot(0));
    end
    tick();
    bus.req_valid[0] = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (bus.rsp_valid !== onehot(0)) begin
      n_err++;
      $display("FAIL rst_mid_rsp0: rsp_valid=%b required %b", bus.rsp_valid, onehot(0));
    end
    tick();
    wait_grant(waited);
    n_cmp++;
    if (bus.req_ready !== onehot(1)) begin
      n_err++;
      $display("FAIL rst_mid_grant1: req_ready=%b required %b", bus.req_ready, onehot(1));
    end
    tick();
    bus.req_valid[1] = 1'b0;
    tick();
    last_g = 1;
  endtask

  task automatic test_out_of_range();
`ifdef RAM_DBG_RANGE_CHECK_EN
    int waited;
    tick();
    bus.req_valid[1] = 1'b1;
    bus.req_write[1] = 1'b0;
    bus.req_addr[12 +: 12] = 12'h123;
    wait_grant(waited);
    n_cmp++;
    if (bus.req_ready !== onehot(1)) begin
      n_err++;
      $display("FAIL oor_grant: req_ready=%b required %b", bus.req_ready, onehot(1));
    end
    tick();
    bus.req_valid[1] = 1'b0;
    #1;
    n_cmp++;
    if (bus.dbg_ren !== 1'b0 || bus.rsp_valid !== onehot(1) || bus.rsp_err !== 1'b1 || bus.rsp_data !== 8'h00) begin
      n_err++;
      $display("FAIL oor_rsp: ren=%b valid=%b err=%b data=%h required ren=0 valid=%b err=1 data=00",
               bus.dbg_ren, bus.rsp_valid, bus.rsp_err, bus.rsp_data, onehot(1));
    end
    last_g = 1;
`else
    do_txn(1, 1'b0, 12'h123, 8'h00, 0, -1, "oor_read");
`endif
  endtask

  initial begin
    bus.req_valid     = '0;
    bus.req_write     = '0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.dbg_rdata     = '0;
    bus.dbg_rdata_vld = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    test_reset();
    test_read_basic();
    test_back_to_back();
    test_blocked();
    test_vld_cases();
    test_random_rw();
    test_rst_mid();
    test_out_of_range();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
